// File: rtl/nr_div_seq_ctrl_pkg.sv
// Shared definitions for the non-restoring division sequencer.
// Holds the default operand width and the FSM state encoding used by the
// controller. The state values are fixed so that waveforms and any external
// debug logic see IDLE=0, ITER=1, RESTORE=2, DONE=3.
package nr_div_seq_ctrl_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ITER    = 2'd1,
    S_RESTORE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/nr_div_seq_ctrl_addsub5.sv
// nr_addsub5: W-bit adder/subtractor shared by every step of the divider.
// Ports:
//   a  in  W  first operand
//   b  in  W  second operand
//   m  in  1  mode: 0 = a + b, 1 = a - b (computed as a + ~b + 1)
//   y  out W  result, wraps modulo 2^W
module nr_addsub5 #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic [W-1:0] y
);

  logic [W-1:0] b_eff;

  // Subtraction reuses the adder: invert b and feed the mode bit in as the
  // carry-in, so a single carry chain serves both operations.
  always_comb begin
    b_eff = m ? ~b : b;
    y     = a + b_eff + W'(m);
  end

endmodule

// File: rtl/nr_div_seq_ctrl.sv
// nr_div_seq_ctrl: multi-cycle non-restoring unsigned divider X / Y.
// One shift + add/sub step per clock on a single shared (N+1)-bit unit,
// followed by one remainder-restore step.
// Ports:
//   clk          in   1    rising-edge clock
//   rst_n        in   1    asynchronous active-low reset
//   start        in   1    request, only looked at in IDLE
//   dividend     in   N    X, captured on the accepted start
//   divisor      in   N    Y, captured on the accepted start
//   busy         out  1    high in ITER, RESTORE and DONE
//   done         out  1    one-cycle pulse, results valid from here on
//   quotient     out  N    Q, held until the next accepted start
//   remainder    out  N+1  R, sign bit is always 0
//   div_by_zero  out  1    set together with done when Y == 0
module nr_div_seq_ctrl
  import nr_div_seq_ctrl_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N:0]   remainder,
  output logic         div_by_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t state, next_state;

  logic [N:0]    a_reg;
  logic [N-1:0]  qr;
  logic [N-1:0]  yr;
  logic [CW-1:0] cnt;

  logic [N:0] addsub_a;
  logic [N:0] addsub_y;
  logic       addsub_m;
  logic       last_iter;

  assign last_iter = (cnt == CW'(N - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A zero divisor skips the iterations entirely and goes
  // straight to DONE with the saturated quotient.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = (divisor == '0) ? S_DONE : S_ITER;
        end
      end
      S_ITER: begin
        if (last_iter) begin
          next_state = S_RESTORE;
        end
      end
      S_RESTORE: next_state = S_DONE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Output and datapath-control logic. In ITER the sign of the partial
  // remainder picks add (negative) or subtract (non-negative); RESTORE
  // always adds the divisor back.
  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    addsub_m = (state == S_ITER) ? ~a_reg[N] : 1'b0;
    addsub_a = (state == S_ITER) ? {a_reg[N-1:0], qr[N-1]} : a_reg;
  end

  nr_addsub5 #(
    .W(N + 1)
  ) u_addsub (
    .a(addsub_a),
    .b({1'b0, yr}),
    .m(addsub_m),
    .y(addsub_y)
  );

  // Working registers and result registers. Results only change on the
  // edge that enters DONE; div_by_zero is also cleared when a normal
  // division is accepted so a stale flag never outlives its operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      qr          <= '0;
      yr          <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              a_reg       <= '0;
              qr          <= dividend;
              yr          <= divisor;
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end else begin
              quotient    <= '1;
              remainder   <= {1'b0, dividend};
              div_by_zero <= 1'b1;
            end
          end
        end
        S_ITER: begin
          a_reg <= addsub_y;
          qr    <= {qr[N-2:0], ~addsub_y[N]};
          cnt   <= cnt + CW'(1);
        end
        S_RESTORE: begin
          if (a_reg[N]) begin
            a_reg     <= addsub_y;
            remainder <= addsub_y;
          end else begin
            remainder <= a_reg;
          end
          quotient <= qr;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nr_div_seq_ctrl.sv
// Self-checking bench for nr_div_seq_ctrl (N = 4).
// A table of directed divisions is run back to back, followed by hand-written
// sequences for start-while-busy, start-during-DONE and reset mid-operation.
module tb_nr_div_seq_ctrl;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N:0]   remainder;
  logic         div_by_zero;

  int total_checks;
  int passed_checks;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] q;
    logic [N:0]   r;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  nr_div_seq_ctrl #(.N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports any miss.
  task automatic checkOutput(input string name, input int actual, input int expected);
    total_checks++;
    if (actual == expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issues one start pulse at a falling edge, scrambles the operand inputs
  // once the request is accepted, and waits (bounded) for done. Reports the
  // cycle number of done (-1 on timeout) and whether busy stayed high.
  task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] y,
                               output int lat, output bit busy_ok);
    int cyc;
    @(negedge clk);
    start    = 1'b1;
    dividend = x;
    divisor  = y;
    @(negedge clk);
    start    = 1'b0;
    dividend = ~x;
    divisor  = ~y;
    cyc      = 1;
    busy_ok  = 1'b1;
    while (!done && cyc < 30) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!busy) busy_ok = 1'b0;
    lat = done ? cyc : -1;
  endtask

  initial begin
    int  lat;
    int  cyc;
    bit  busy_ok;
    bit  saw_done;
    bit  busy_seen;

    total_checks  = 0;
    passed_checks = 0;

    vecs[0] = '{x: 4'd13, y: 4'd3,  q: 4'd4,  r: 5'd1, dbz: 1'b0, lat: 6};
    vecs[1] = '{x: 4'd15, y: 4'd1,  q: 4'd15, r: 5'd0, dbz: 1'b0, lat: 6};
    vecs[2] = '{x: 4'd2,  y: 4'd7,  q: 4'd0,  r: 5'd2, dbz: 1'b0, lat: 6};
    vecs[3] = '{x: 4'd9,  y: 4'd0,  q: 4'd15, r: 5'd9, dbz: 1'b1, lat: 1};
    vecs[4] = '{x: 4'd14, y: 4'd5,  q: 4'd2,  r: 5'd4, dbz: 1'b0, lat: 6};
    vecs[5] = '{x: 4'd0,  y: 4'd9,  q: 4'd0,  r: 5'd0, dbz: 1'b0, lat: 6};
    vecs[6] = '{x: 4'd15, y: 4'd15, q: 4'd1,  r: 5'd0, dbz: 1'b0, lat: 6};
    vecs[7] = '{x: 4'd7,  y: 4'd2,  q: 4'd3,  r: 5'd1, dbz: 1'b0, lat: 6};

    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset quotient", int'(quotient), 0);
    checkOutput("reset remainder", int'(remainder), 0);
    checkOutput("reset div_by_zero", int'(div_by_zero), 0);
    rst_n = 1'b1;

    $display("[TB] table-driven divisions");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, lat, busy_ok);
      checkOutput($sformatf("v%0d latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("v%0d busy", i), int'(busy_ok), 1);
      checkOutput($sformatf("v%0d quotient", i), int'(quotient), int'(vecs[i].q));
      checkOutput($sformatf("v%0d remainder", i), int'(remainder), int'(vecs[i].r));
      checkOutput($sformatf("v%0d div_by_zero", i), int'(div_by_zero), int'(vecs[i].dbz));
      @(negedge clk);
      checkOutput($sformatf("v%0d done pulse", i), int'(done), 0);
      checkOutput($sformatf("v%0d idle busy", i), int'(busy), 0);
      checkOutput($sformatf("v%0d quotient held", i), int'(quotient), int'(vecs[i].q));
    end

    $display("[TB] start while busy is ignored");
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd2;
    @(negedge clk);
    start = 1'b0;
    cyc   = 4;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("busy-start latency", done ? cyc : -1, 6);
    checkOutput("busy-start quotient", int'(quotient), 4);
    checkOutput("busy-start remainder", int'(remainder), 1);

    $display("[TB] start during DONE is ignored");
    start    = 1'b1;
    dividend = 4'd9;
    divisor  = 4'd0;
    @(negedge clk);
    checkOutput("done-start busy", int'(busy), 0);
    checkOutput("done-start div_by_zero", int'(div_by_zero), 0);
    start = 1'b0;
    @(negedge clk);

    $display("[TB] reset mid-operation");
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort quotient", int'(quotient), 0);
    checkOutput("abort remainder", int'(remainder), 0);
    saw_done  = 1'b0;
    busy_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) rst_n = 1'b1;
      if (done) saw_done = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
    checkOutput("abort no done", int'(saw_done), 0);
    checkOutput("abort stays idle", int'(busy_seen), 0);

    applyStimulus(4'd6, 4'd2, lat, busy_ok);
    checkOutput("post-reset latency", lat, 6);
    checkOutput("post-reset quotient", int'(quotient), 3);
    checkOutput("post-reset remainder", int'(remainder), 0);
    checkOutput("post-reset div_by_zero", int'(div_by_zero), 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
